// File: rtl/ahb_signal_slave_pkg.sv
// Shared definitions for the AHB signal slave: register map, default words,
// bus encodings, FSM state constants and the address decoder.
package ahb_signal_slave_pkg;

    localparam logic [31:0] ADDR_START  = 32'h5000_0000;
    localparam logic [31:0] ADDR_END    = 32'h5000_0004;
    localparam logic [31:0] ADDR_STATUS = 32'h5000_0008;

    localparam logic [31:0] DEFAULT_START_WORD = 32'h0102_0304;
    localparam logic [31:0] DEFAULT_END_WORD   = 32'h0403_0201;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_BUSY   = 2'b01;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] SIZE_WORD = 3'b010;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_WAIT = 3'd1;
    localparam state_t S_DATA = 3'd2;
    localparam state_t S_ERR1 = 3'd3;
    localparam state_t S_ERR2 = 3'd4;

    typedef enum logic [1:0] {
        REG_START,
        REG_END,
        REG_STATUS,
        REG_NONE
    } reg_sel_t;

    // Address-phase information held for the data phase.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
    } req_t;

    function automatic reg_sel_t decode_addr(input logic [31:0] addr);
        case (addr)
            ADDR_START:  return REG_START;
            ADDR_END:    return REG_END;
            ADDR_STATUS: return REG_STATUS;
            default:     return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ahb_signal_slave_if.sv
// AHB-style bus bundle between a master and the signal slave.
interface ahb_signal_slave_if;

    logic [31:0] ADDR;
    logic [1:0]  TRANS;
    logic [2:0]  BURST;
    logic [2:0]  hsize;
    logic        SEL;
    logic [3:0]  PROT;
    logic        HWRITE;
    logic [31:0] WDATA;
    logic        READY_in;
    logic [31:0] RDATA;
    logic        READY_out;
    logic        RESP;

    modport master (
        output ADDR, TRANS, BURST, hsize, SEL, PROT, HWRITE, WDATA, READY_in,
        input  RDATA, READY_out, RESP
    );

    modport slave (
        input  ADDR, TRANS, BURST, hsize, SEL, PROT, HWRITE, WDATA, READY_in,
        output RDATA, READY_out, RESP
    );

endinterface

// File: rtl/ahb_signal_slave.sv
// Single-transfer AHB slave with START/END/STATUS registers, programmable
// wait states, two-cycle ERROR response and a sticky end_flag.
module ahb_signal_slave
    import ahb_signal_slave_pkg::*;
#(
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] START_WORD  = DEFAULT_START_WORD,
    parameter logic [31:0] END_WORD    = DEFAULT_END_WORD
) (
    input  logic              clk,
    input  logic              reset,
    ahb_signal_slave_if.slave bus,
    input  logic              host_go,
    input  logic              host_clear,
    output logic              end_flag
);

    localparam logic [1:0] WAIT_LOAD = (WAIT_STATES > 0) ? 2'(WAIT_STATES - 1) : 2'd0;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  wait_cnt;
    req_t        req_q;

    logic [31:0] start_reg;
    logic [31:0] end_reg;
    logic        end_flag_q;
    logic [31:0] rdata_q;

    logic        accept;
    reg_sel_t    acc_sel;
    logic        acc_err;

    reg_sel_t    rd_sel;
    logic        rd_write;
    logic        load_rdata;
    logic [31:0] rd_value;
    logic [31:0] status_word;

    reg_sel_t    wr_sel;
    logic        commit_wr;

    // Address phase: only the idle state listens to the bus.
    assign accept  = (state == S_IDLE) && bus.SEL && bus.TRANS[1];
    assign acc_sel = decode_addr(bus.ADDR);
    assign acc_err = (acc_sel == REG_NONE) || (bus.hsize != SIZE_WORD) ||
                     (bus.HWRITE && (acc_sel == REG_STATUS));

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (acc_err)              state_nxt = S_ERR1;
                    else if (WAIT_STATES > 0) state_nxt = S_WAIT;
                    else                      state_nxt = S_DATA;
                end
            end
            S_WAIT:  if (wait_cnt == 2'd0) state_nxt = S_DATA;
            S_DATA:  state_nxt = S_IDLE;
            S_ERR1:  state_nxt = S_ERR2;
            S_ERR2:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign status_word = {30'b0, end_flag_q, start_reg == START_WORD};

    // RDATA is registered, so the read value is fetched on the edge that
    // enters S_DATA; with zero wait states that edge is the accept itself.
    assign rd_sel     = (state == S_IDLE) ? acc_sel : decode_addr(req_q.addr);
    assign rd_write   = (state == S_IDLE) ? bus.HWRITE : req_q.write;
    assign load_rdata = (state_nxt == S_DATA) && !rd_write;

    always_comb begin
        rd_value = '0;
        case (rd_sel)
            REG_START:  rd_value = start_reg;
            REG_END:    rd_value = end_reg;
            REG_STATUS: rd_value = status_word;
            default:    rd_value = '0;
        endcase
    end

    assign wr_sel    = decode_addr(req_q.addr);
    assign commit_wr = (state == S_DATA) && req_q.write;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= 2'd0;
            rdata_q  <= '0;
        end else begin
            state   <= state_nxt;
            rdata_q <= load_rdata ? rd_value : '0;
            if (state == S_IDLE)
                wait_cnt <= WAIT_LOAD;
            else if ((state == S_WAIT) && (wait_cnt != 2'd0))
                wait_cnt <= wait_cnt - 2'd1;
        end
    end

    // NOTE: the captured request carries no reset; it is only consumed
    // after an accept has overwritten it, so a reset term buys nothing.
    always_ff @(posedge clk) begin
        if (accept)
            req_q <= '{addr: bus.ADDR, write: bus.HWRITE, size: bus.hsize};
    end

    // Register file: host_clear beats a committing bus write beats host_go.
    always_ff @(posedge clk) begin
        if (!reset) begin
            start_reg  <= '0;
            end_reg    <= '0;
            end_flag_q <= 1'b0;
        end else if (host_clear) begin
            start_reg  <= '0;
            end_reg    <= '0;
            end_flag_q <= 1'b0;
        end else begin
            if (commit_wr && (wr_sel == REG_START))
                start_reg <= bus.WDATA;
            else if (host_go)
                start_reg <= START_WORD;

            if (commit_wr && (wr_sel == REG_END)) begin
                end_reg <= bus.WDATA;
                if (bus.WDATA == END_WORD)
                    end_flag_q <= 1'b1;
            end
        end
    end

    assign bus.RDATA     = rdata_q;
    assign bus.READY_out = (state != S_WAIT) && (state != S_ERR1);
    assign bus.RESP      = (state == S_ERR1) || (state == S_ERR2);
    assign end_flag      = end_flag_q;

    // Bus fields this slave deliberately does not act on.
    logic unused_bus;
    assign unused_bus = ^{bus.BURST, bus.PROT, bus.READY_in, bus.TRANS[0], req_q.size};

endmodule

// File: tb/tb_ahb_signal_slave.sv
// Directed plus randomized bench for ahb_signal_slave against a
// transaction-level register model.
module tb_ahb_signal_slave;

    localparam int          WS         = 1;
    localparam logic [31:0] A_START    = 32'h5000_0000;
    localparam logic [31:0] A_END      = 32'h5000_0004;
    localparam logic [31:0] A_STATUS   = 32'h5000_0008;
    localparam logic [31:0] A_HOLE     = 32'h5000_000C;
    localparam logic [31:0] START_WORD = 32'h0102_0304;
    localparam logic [31:0] END_WORD   = 32'h0403_0201;

    logic clk = 1'b0;
    logic reset;
    logic host_go;
    logic host_clear;
    logic end_flag;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_start;
    logic [31:0] m_end;
    logic        m_flag;

    ahb_signal_slave_if bus_if ();

    ahb_signal_slave #(
        .WAIT_STATES (WS),
        .START_WORD  (START_WORD),
        .END_WORD    (END_WORD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .host_go    (host_go),
        .host_clear (host_clear),
        .end_flag   (end_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] addr, input logic [2:0] size, input bit write);
        return (size == 3'b010) &&
               (addr == A_START || addr == A_END || (addr == A_STATUS && !write));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        if (addr == A_START)  return m_start;
        if (addr == A_END)    return m_end;
        if (addr == A_STATUS) return {30'b0, m_flag, m_start == START_WORD};
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_start = '0;
        m_end   = '0;
        m_flag  = 1'b0;
    endtask

    task automatic idle_bus();
        bus_if.SEL   = 1'b0;
        bus_if.TRANS = 2'b00;
        bus_if.ADDR  = $urandom;
    endtask

    task automatic junk_phase();
        bus_if.SEL    = 1'b1;
        bus_if.TRANS  = 2'b10;
        bus_if.ADDR   = ($urandom_range(0, 1) == 0) ? A_START : A_HOLE;
        bus_if.HWRITE = 1'($urandom_range(0, 1));
        bus_if.hsize  = 3'b010;
    endtask

    // One complete transfer, checked cycle by cycle against the model.
    task automatic do_xfer(input logic [31:0] addr, input bit write, input logic [2:0] size,
                           input logic [31:0] wdata, input bit junk, input bit clr, input bit go);
        bit          ok;
        logic [31:0] exp_rd;
        ok     = legal(addr, size, write);
        exp_rd = model_read(addr);

        bus_if.ADDR   = addr;
        bus_if.TRANS  = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
        bus_if.SEL    = 1'b1;
        bus_if.HWRITE = write;
        bus_if.hsize  = size;
        bus_if.BURST  = 3'($urandom);
        bus_if.PROT   = 4'($urandom);
        bus_if.WDATA  = $urandom;
        @(negedge clk);
        check("idle_ready", 32'(bus_if.READY_out), 32'd1);
        check("idle_resp",  32'(bus_if.RESP),      32'd0);
        check("idle_rdata", bus_if.RDATA,          32'd0);
        check("end_flag",   32'(end_flag),         32'(m_flag));
        @(posedge clk); #1;
        idle_bus();
        bus_if.WDATA = $urandom;

        if (ok) begin
            repeat (WS) begin
                @(negedge clk);
                check("wait_ready", 32'(bus_if.READY_out), 32'd0);
                check("wait_resp",  32'(bus_if.RESP),      32'd0);
                check("wait_rdata", bus_if.RDATA,          32'd0);
                @(posedge clk); #1;
            end
            bus_if.WDATA = wdata;
            if (junk) junk_phase();
            host_clear = clr;
            host_go    = go;
            @(negedge clk);
            check("data_ready", 32'(bus_if.READY_out), 32'd1);
            check("data_resp",  32'(bus_if.RESP),      32'd0);
            check("data_rdata", bus_if.RDATA,          write ? 32'd0 : exp_rd);
            @(posedge clk); #1;
            idle_bus();
            host_clear = 1'b0;
            host_go    = 1'b0;
            if (clr) begin
                model_reset();
            end else begin
                if (write && addr == A_START) m_start = wdata;
                else if (go)                  m_start = START_WORD;
                if (write && addr == A_END) begin
                    m_end = wdata;
                    if (wdata == END_WORD) m_flag = 1'b1;
                end
            end
        end else begin
            @(negedge clk);
            check("err1_ready", 32'(bus_if.READY_out), 32'd0);
            check("err1_resp",  32'(bus_if.RESP),      32'd1);
            check("err1_rdata", bus_if.RDATA,          32'd0);
            @(posedge clk); #1;
            if (junk) junk_phase();
            host_clear = clr;
            host_go    = go;
            @(negedge clk);
            check("err2_ready", 32'(bus_if.READY_out), 32'd1);
            check("err2_resp",  32'(bus_if.RESP),      32'd1);
            check("err2_rdata", bus_if.RDATA,          32'd0);
            @(posedge clk); #1;
            idle_bus();
            host_clear = 1'b0;
            host_go    = 1'b0;
            if (clr)     model_reset();
            else if (go) m_start = START_WORD;
        end
    endtask

    task automatic pulse_go();
        host_go = 1'b1;
        @(posedge clk); #1;
        host_go = 1'b0;
        m_start = START_WORD;
    endtask

    task automatic pulse_clear();
        host_clear = 1'b1;
        @(posedge clk); #1;
        host_clear = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [31:0] r_addr;
        logic [31:0] r_data;
        logic [2:0]  r_size;

        reset           = 1'b0;
        host_go         = 1'b0;
        host_clear      = 1'b0;
        bus_if.BURST    = 3'b000;
        bus_if.PROT     = 4'h0;
        bus_if.HWRITE   = 1'b0;
        bus_if.hsize    = 3'b010;
        bus_if.WDATA    = '0;
        bus_if.READY_in = 1'b1;
        idle_bus();
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready",    32'(bus_if.READY_out), 32'd1);
        check("rst_resp",     32'(bus_if.RESP),      32'd0);
        check("rst_rdata",    bus_if.RDATA,          32'd0);
        check("rst_end_flag", 32'(end_flag),         32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Reset-state read, then host_go and readback of START and STATUS.
        do_xfer(A_START, 1'b0, 3'b010, '0, 1'b0, 1'b0, 1'b0);
        pulse_go();
        do_xfer(A_START,  1'b0, 3'b010, '0, 1'b0, 1'b0, 1'b0);
        do_xfer(A_STATUS, 1'b0, 3'b010, '0, 1'b0, 1'b0, 1'b0);

        // END_WORD sets the sticky flag; STATUS then reads 3.
        do_xfer(A_END, 1'b1, 3'b010, END_WORD, 1'b0, 1'b0, 1'b0);
        check("flag_after_end", 32'(end_flag), 32'd1);
        do_xfer(A_STATUS, 1'b0, 3'b010, '0, 1'b0, 1'b0, 1'b0);

        // Error responses leave STATUS untouched.
        do_xfer(A_HOLE,   1'b0, 3'b010, '0,           1'b0, 1'b0, 1'b0);
        do_xfer(A_STATUS, 1'b1, 3'b010, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        do_xfer(A_STATUS, 1'b0, 3'b010, '0,           1'b0, 1'b0, 1'b0);

        // Illegal size, then same-cycle priorities on START_REG.
        do_xfer(A_START, 1'b1, 3'b001, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        do_xfer(A_START, 1'b0, 3'b010, '0,           1'b0, 1'b0, 1'b0);
        do_xfer(A_START, 1'b1, 3'b010, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0);
        do_xfer(A_START, 1'b0, 3'b010, '0,           1'b0, 1'b0, 1'b0);
        do_xfer(A_START, 1'b1, 3'b010, 32'h1234_5678, 1'b0, 1'b0, 1'b1);
        do_xfer(A_START, 1'b0, 3'b010, '0,           1'b0, 1'b0, 1'b0);

        // Any later END_REG write keeps the flag; new address phases in
        // S_DATA/S_ERR2 are ignored.
        do_xfer(A_END, 1'b1, 3'b010, END_WORD,      1'b1, 1'b0, 1'b0);
        do_xfer(A_END, 1'b1, 3'b010, 32'h0000_1111, 1'b1, 1'b0, 1'b0);
        do_xfer(A_HOLE, 1'b1, 3'b010, '0,           1'b1, 1'b0, 1'b0);
        do_xfer(A_STATUS, 1'b0, 3'b010, '0,         1'b0, 1'b0, 1'b0);
        pulse_clear();
        do_xfer(A_STATUS, 1'b0, 3'b010, '0,         1'b0, 1'b0, 1'b0);

        // Reset while a write of END_WORD sits in its wait state.
        pulse_go();
        bus_if.ADDR   = A_END;
        bus_if.TRANS  = 2'b10;
        bus_if.SEL    = 1'b1;
        bus_if.HWRITE = 1'b1;
        bus_if.hsize  = 3'b010;
        @(posedge clk); #1;
        idle_bus();
        bus_if.WDATA = END_WORD;
        reset        = 1'b0;
        @(negedge clk);
        check("midrst_wait_ready", 32'(bus_if.READY_out), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("midrst_ready",    32'(bus_if.READY_out), 32'd1);
        check("midrst_end_flag", 32'(end_flag),         32'd0);
        @(posedge clk); #1;
        do_xfer(A_END,    1'b0, 3'b010, '0, 1'b0, 1'b0, 1'b0);
        do_xfer(A_STATUS, 1'b0, 3'b010, '0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with occasional host pulses.
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 5))
                0:       r_addr = A_START;
                1:       r_addr = A_END;
                2:       r_addr = A_STATUS;
                3:       r_addr = A_HOLE;
                4:       r_addr = $urandom;
                default: r_addr = A_END;
            endcase
            case ($urandom_range(0, 3))
                0:       r_data = END_WORD;
                1:       r_data = START_WORD;
                default: r_data = $urandom;
            endcase
            r_size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            do_xfer(r_addr, 1'($urandom_range(0, 1)), r_size, r_data,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) pulse_go();
            if ($urandom_range(0, 19) == 0) pulse_clear();
        end
        do_xfer(A_STATUS, 1'b0, 3'b010, '0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
